// File: rtl/tm1638_pkg.sv
// Shared constants, state type and key-stream helper for the TM1638 responder.
package tm1638_pkg;

    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_CTRL = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;
    localparam int unsigned RAM_DEPTH = 16;
    localparam int unsigned KEY_BYTES = 4;

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, IGNORE} tm_state_t;

    // Bit idx of the 32-bit key stream: byte i = {3'b0, k[i+4], 3'b0, k[i]}.
    function automatic logic key_bit(input logic [7:0] k, input logic [4:0] idx);
        logic result;
        result = 1'b0;
        if (idx[2:0] == 3'd0) begin
            result = k[{1'b0, idx[4:3]}];
        end else if (idx[2:0] == 3'd4) begin
            result = k[{1'b1, idx[4:3]}];
        end
        return result;
    endfunction

endpackage

// File: rtl/tm1638_responder_if.sv
// Three-wire TM1638 link (STB/CLK/DIO) with split DIO drive for the responder side.
interface tm1638_responder_if;

    logic tm_strobe;
    logic tm_clock;
    logic tm_dio_in;
    logic tm_dio_out;
    logic tm_dio_oe;

    modport master (
        output tm_strobe,
        output tm_clock,
        output tm_dio_in,
        input  tm_dio_out,
        input  tm_dio_oe
    );

    modport slave (
        input  tm_strobe,
        input  tm_clock,
        input  tm_dio_in,
        output tm_dio_out,
        output tm_dio_oe
    );

endinterface

// File: rtl/tm_sync_edge.sv
// Multi-flop synchronizer with edge detect; resets to the idle-high link level.
module tm_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages_q;
    logic                   prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stages_q <= '1;
            prev_q   <= 1'b1;
        end else begin
            stages_q <= {stages_q[SYNC_STAGES-2:0], din};
            prev_q   <= stages_q[SYNC_STAGES-1];
        end
    end

    assign sync = stages_q[SYNC_STAGES-1];
    assign rise = sync & ~prev_q;
    assign fall = ~sync & prev_q;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device-side responder: decodes the oversampled link, holds display RAM,
// and serializes latched key bytes on read commands.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clock,
    input  logic                reset,
    tm1638_responder_if.slave   link,
    input  logic [7:0]          keys,
    output logic [7:0]          display0,
    output logic [7:0]          display1,
    output logic [7:0]          display2,
    output logic [7:0]          display3,
    output logic [7:0]          display4,
    output logic [7:0]          display5,
    output logic [7:0]          display6,
    output logic [7:0]          display7,
    output logic [7:0]          leds,
    output logic [2:0]          brightness,
    output logic                display_on,
    output logic                update
);

    logic stb_sync, stb_rise, stb_fall;
    logic clk_sync, clk_rise, clk_fall;
    logic dio_sync, dio_rise, dio_fall;

    tm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stb (
        .clock(clock), .reset(reset), .din(link.tm_strobe),
        .sync(stb_sync), .rise(stb_rise), .fall(stb_fall)
    );
    tm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clock(clock), .reset(reset), .din(link.tm_clock),
        .sync(clk_sync), .rise(clk_rise), .fall(clk_fall)
    );
    tm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dio (
        .clock(clock), .reset(reset), .din(link.tm_dio_in),
        .sync(dio_sync), .rise(dio_rise), .fall(dio_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{stb_sync, clk_sync, dio_rise, dio_fall};

    tm_state_t  state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] addr_q, addr_d;
    logic       fixed_q, fixed_d;
    logic [7:0] key_q, key_d;
    logic [5:0] rd_idx_q, rd_idx_d;
    logic       dio_out_q, dio_out_d;
    logic       oe_q, oe_d;
    logic       update_q, update_d;
    logic [2:0] brightness_q, brightness_d;
    logic       display_on_q, display_on_d;
    logic [7:0] ram_q [RAM_DEPTH];
    logic       ram_we;
    logic [7:0] full_byte;
    logic       byte_done;

    // LSB first: the newest bit enters at the top and shifts down.
    assign full_byte = {dio_sync, shift_q[7:1]};
    assign byte_done = clk_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        addr_d       = addr_q;
        fixed_d      = fixed_q;
        key_d        = key_q;
        rd_idx_d     = rd_idx_q;
        dio_out_d    = dio_out_q;
        oe_d         = oe_q;
        update_d     = 1'b0;
        brightness_d = brightness_q;
        display_on_d = display_on_q;
        ram_we       = 1'b0;

        // STB edges take priority so a byte finishing as STB rises is dropped.
        if (stb_rise) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            dio_out_d = 1'b1;
        end else if (stb_fall) begin
            state_d   = CMD;
            bit_cnt_d = '0;
            oe_d      = 1'b0;
            dio_out_d = 1'b1;
        end else begin
            if (clk_rise && state_q != IDLE) begin
                shift_d   = full_byte;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
            unique case (state_q)
                CMD: begin
                    if (byte_done) begin
                        unique case (full_byte[7:6])
                            CMD_DATA: begin
                                fixed_d = full_byte[2];
                                if (full_byte[1]) begin
                                    key_d    = keys;
                                    rd_idx_d = '0;
                                    state_d  = RDATA;
                                end else begin
                                    state_d = IGNORE;
                                end
                            end
                            CMD_ADDR: begin
                                addr_d  = full_byte[3:0];
                                state_d = WDATA;
                            end
                            CMD_CTRL: begin
                                display_on_d = full_byte[3];
                                brightness_d = full_byte[2:0];
                                state_d      = IGNORE;
                            end
                            default: state_d = IGNORE;
                        endcase
                    end
                end
                WDATA: begin
                    if (byte_done) begin
                        ram_we   = 1'b1;
                        update_d = 1'b1;
                        if (!fixed_q) addr_d = addr_q + 4'd1;
                    end
                end
                RDATA: begin
                    // rd_idx saturates at 32 so bytes past the fourth read as zero.
                    if (clk_fall) begin
                        oe_d = 1'b1;
                        if (rd_idx_q[5]) begin
                            dio_out_d = 1'b0;
                        end else begin
                            dio_out_d = key_bit(key_q, rd_idx_q[4:0]);
                            rd_idx_d  = rd_idx_q + 6'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            fixed_q      <= 1'b0;
            key_q        <= '0;
            rd_idx_q     <= '0;
            dio_out_q    <= 1'b1;
            oe_q         <= 1'b0;
            update_q     <= 1'b0;
            brightness_q <= '0;
            display_on_q <= 1'b0;
            for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            fixed_q      <= fixed_d;
            key_q        <= key_d;
            rd_idx_q     <= rd_idx_d;
            dio_out_q    <= dio_out_d;
            oe_q         <= oe_d;
            update_q     <= update_d;
            brightness_q <= brightness_d;
            display_on_q <= display_on_d;
            if (ram_we) ram_q[addr_q] <= full_byte;
        end
    end

    assign link.tm_dio_out = dio_out_q;
    assign link.tm_dio_oe  = oe_q;
    assign update          = update_q;
    assign brightness      = brightness_q;
    assign display_on      = display_on_q;

    assign display0 = ram_q[0];
    assign display1 = ram_q[2];
    assign display2 = ram_q[4];
    assign display3 = ram_q[6];
    assign display4 = ram_q[8];
    assign display5 = ram_q[10];
    assign display6 = ram_q[12];
    assign display7 = ram_q[14];

    for (genvar g = 0; g < 8; g++) begin : g_led
        assign leds[g] = ram_q[2*g+1][0];
    end

endmodule

// File: tb/tb_tm1638_responder.sv
// Bench for tm1638_responder: bit-banged controller frames against a frame-level model.
module tb_tm1638_responder;

    localparam int HOLD = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [7:0] keys = 8'h00;
    logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic [7:0] leds;
    logic [2:0] brightness;
    logic       display_on;
    logic       update;

    tm1638_responder_if link ();

    tm1638_responder #(.SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .link(link), .keys(keys),
        .display0(d0), .display1(d1), .display2(d2), .display3(d3),
        .display4(d4), .display5(d5), .display6(d6), .display7(d7),
        .leds(leds), .brightness(brightness), .display_on(display_on), .update(update)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;

    // Frame-level model of the device.
    logic [7:0] exp_ram [16];
    logic [2:0] exp_bri;
    logic       exp_on;
    logic       exp_fixed;
    logic [3:0] exp_addr;
    logic       exp_oe;
    logic       f_write, f_read;
    logic [7:0] kb [4];
    logic [7:0] rd_got [8];
    int         upd_exp = 0;
    int         upd_seen = 0;
    logic       settled = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [63:0] exp_disp();
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = exp_ram[2*i];
        return v;
    endfunction

    function automatic logic [7:0] exp_leds();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = exp_ram[2*i+1][0];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) exp_ram[i] = 8'h00;
        exp_bri = 3'd0; exp_on = 1'b0; exp_fixed = 1'b0; exp_addr = 4'd0;
        exp_oe = 1'b0; f_write = 1'b0; f_read = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input logic is_cmd);
        if (is_cmd) begin
            case (b[7:6])
                2'b01: begin
                    exp_fixed = b[2];
                    if (b[1]) begin
                        f_read = 1'b1;
                        for (int i = 0; i < 4; i++)
                            kb[i] = {3'b000, keys[i+4], 3'b000, keys[i]};
                    end
                end
                2'b11: begin exp_addr = b[3:0]; f_write = 1'b1; end
                2'b10: begin exp_on = b[3]; exp_bri = b[2:0]; end
                default: ;
            endcase
        end else if (f_write) begin
            exp_ram[exp_addr] = b;
            upd_exp++;
            if (!exp_fixed) exp_addr = exp_addr + 4'd1;
        end
    endtask

    always @(negedge clock) begin
        if (update === 1'b1) upd_seen++;
        if (settled && !reset) begin
            check("display", {d7, d6, d5, d4, d3, d2, d1, d0}, exp_disp());
            check("leds", leds, exp_leds());
            check("brightness", brightness, exp_bri);
            check("display_on", display_on, exp_on);
            check("dio_oe", link.tm_dio_oe, exp_oe);
            if (!exp_oe) check("dio_idle", link.tm_dio_out, 1'b1);
        end
    end

    task automatic drive(input logic s, input logic c, input logic d);
        @(posedge clock); #1;
        settled = 1'b0;
        link.tm_strobe = s; link.tm_clock = c; link.tm_dio_in = d;
    endtask

    task automatic hold();
        repeat (HOLD) @(posedge clock);
        #1 settled = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, b[i]); hold();
            drive(1'b0, 1'b1, b[i]); hold();
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic is_cmd);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, b[i]); hold();
            drive(1'b0, 1'b1, b[i]);
            if (i == 7) model_byte(b, is_cmd);
            hold();
        end
    endtask

    task automatic stb_fall();
        drive(1'b0, 1'b1, 1'b1); hold();
    endtask

    task automatic end_frame();
        drive(1'b1, 1'b1, 1'b1);
        exp_oe = 1'b0; f_write = 1'b0; f_read = 1'b0;
        hold(); hold();
        check("update_count", upd_seen, upd_exp);
    endtask

    task automatic frame(input int n, input logic [7:0] b0, input logic [7:0] b1 = 8'h00,
                         input logic [7:0] b2 = 8'h00, input logic [7:0] b3 = 8'h00,
                         input logic [7:0] b4 = 8'h00);
        logic [7:0] arr [5];
        arr = '{b0, b1, b2, b3, b4};
        stb_fall();
        for (int i = 0; i < n; i++) send_byte(arr[i], i == 0);
        end_frame();
    endtask

    task automatic read_bytes(input int n, input int chg);
        logic [7:0] got;
        logic       bexp;
        for (int j = 0; j < n; j++) begin
            got = 8'h00;
            for (int i = 0; i < 8; i++) begin
                drive(1'b0, 1'b0, 1'b1);
                exp_oe = 1'b1;
                hold();
                bexp = (j < 4) ? kb[j][i] : 1'b0;
                check("read_bit", link.tm_dio_out, bexp);
                got[i] = link.tm_dio_out;
                drive(1'b0, 1'b1, 1'b1); hold();
            end
            rd_got[j] = got;
            if (j == chg) keys = ~keys;
        end
    endtask

    task automatic read_frame(input logic [7:0] cmd, input int n, input int chg);
        stb_fall();
        send_byte(cmd, 1'b1);
        read_bytes(n, chg);
        end_frame();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int base;
        link.tm_strobe = 1'b1; link.tm_clock = 1'b1; link.tm_dio_in = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_display", {d7, d6, d5, d4, d3, d2, d1, d0}, 64'h0);
        check("reset_ctrl", {leds, brightness, display_on, update}, 13'h0);
        check("reset_dio", {link.tm_dio_oe, link.tm_dio_out}, 2'b01);
        reset = 1'b0;
        hold();

        // Write burst, then display control.
        base = upd_seen;
        frame(1, 8'h40);
        frame(5, 8'hC0, 8'h3F, 8'h01, 8'h06, 8'h00);
        frame(1, 8'h8F);
        check("t1_display0", d0, 8'h3F);
        check("t1_display1", d1, 8'h06);
        check("t1_leds", leds, 8'h01);
        check("t1_ctrl", {display_on, brightness}, 4'hF);
        check("t1_updates", upd_seen - base, 4);

        // Fixed address, then auto increment wrapping 0xF -> 0x0.
        frame(1, 8'h44);
        frame(2, 8'hCF, 8'h5B);
        check("t2_led7_fixed", leds[7], 1'b1);
        frame(1, 8'h40);
        frame(3, 8'hCF, 8'h11, 8'h22);
        check("t2_wrap_display0", d0, 8'h22);
        check("t2_led7", leds[7], 1'b1);

        // Key read, one byte past the key bytes.
        keys = 8'b1000_0001;
        read_frame(8'h42, 5, -1);
        check("t3_key0", rd_got[0], 8'h01);
        check("t3_key1", rd_got[1], 8'h00);
        check("t3_key2", rd_got[2], 8'h00);
        check("t3_key3", rd_got[3], 8'h10);
        check("t3_extra", rd_got[4], 8'h00);

        // Abort after 5 data bits; then STB rising together with the 8th CLK rise.
        stb_fall();
        send_byte(8'hC0, 1'b1);
        send_bits(8'hFF, 5);
        end_frame();
        stb_fall();
        send_byte(8'hC4, 1'b1);
        send_bits(8'h77, 7);
        drive(1'b0, 1'b0, 1'b0); hold();
        drive(1'b1, 1'b1, 1'b0);
        exp_oe = 1'b0; f_write = 1'b0;
        hold(); hold();
        check("t4_no_update", upd_seen, upd_exp);
        frame(2, 8'hC2, 8'hAB);
        check("t4_next_frame", d1, 8'hAB);

        // Key latch: keys inverted after the first read byte.
        keys = 8'h5A;
        read_frame(8'h42, 4, 0);
        check("t6_key0", rd_got[0], 8'h10);
        check("t6_key1", rd_got[1], 8'h01);
        check("t6_key2", rd_got[2], 8'h10);
        check("t6_key3", rd_got[3], 8'h01);

        // Randomized frames.
        for (int n = 0; n < 40; n++) begin
            int kind;
            int len;
            kind = $urandom_range(0, 4);
            len = $urandom_range(1, 4);
            case (kind)
                0: frame(1, 8'h40 | (8'($urandom_range(0, 1)) << 2));
                1: frame(len + 1, 8'hC0 | 8'($urandom_range(0, 15)), 8'($urandom),
                         8'($urandom), 8'($urandom), 8'($urandom));
                2: frame(1, 8'h80 | 8'($urandom_range(0, 63)));
                3: begin
                    keys = 8'($urandom);
                    read_frame(8'h42 | (8'($urandom_range(0, 1)) << 2), len + 1,
                               $urandom_range(0, 3));
                end
                default: frame(2, 8'($urandom_range(0, 63)), 8'($urandom));
            endcase
        end

        // Asynchronous reset during the second read byte.
        keys = 8'hFF;
        stb_fall();
        send_byte(8'h42, 1'b1);
        read_bytes(1, -1);
        send_bits(8'hFF, 3);
        settled = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("t5_display", {d7, d6, d5, d4, d3, d2, d1, d0}, 64'h0);
        check("t5_ctrl", {leds, brightness, display_on, update}, 13'h0);
        check("t5_dio", {link.tm_dio_oe, link.tm_dio_out}, 2'b01);
        link.tm_strobe = 1'b1; link.tm_clock = 1'b1; link.tm_dio_in = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        hold();
        frame(3, 8'hC0, 8'h66, 8'h01);
        check("t5_after_reset", {leds[0], d0}, 9'h166);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
